gpio_chain_loader: RTL

GPIO_CHAIN_LOADER -- requirements
Module: gpio_chain_loader

---
 rtl/gpio_chain_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/gpio_chain_loader.sv
// gpio_chain_loader: holds one configuration word per GPIO control block and
// shifts all of them, MSB-first and farthest block first, down a serial chain,
// then pulses serial_load so every block latches its own word.
module gpio_chain_loader #(
  parameter int                       N_GPIO        = 19,
  parameter int                       PAD_CTRL_BITS = 10,
  parameter int                       CLK_DIV       = 2,
  parameter logic [PAD_CTRL_BITS-1:0] DEFAULT_CFG   = 10'h005
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         cfg_we,
  input  logic [$clog2(N_GPIO)-1:0]    cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0]     cfg_wdata,
  output logic [PAD_CTRL_BITS-1:0]     cfg_rdata,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         serial_clock,
  output logic                         serial_data,
  output logic                         serial_load
);

  localparam int AW = $clog2(N_GPIO);
  localparam int B  = PAD_CTRL_BITS;
  localparam int NB = N_GPIO * PAD_CTRL_BITS;
  localparam int BW = $clog2(NB);
  localparam int DW = $clog2(2 * CLK_DIV);

  localparam logic [BW-1:0] BIT_FIRST = BW'(NB - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] LOAD_LAST = DW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    SETTLE,
    LOAD
  } state_e;

  state_e          state_q;
  logic            busy_q;
  logic            done_q;
  logic            sclk_q;
  logic            sdata_q;
  logic            sload_q;
  logic [BW-1:0]   bit_q;
  logic [DW-1:0]   div_q;

  logic [B-1:0]    words_q [N_GPIO];
  logic [B-1:0]    words_d [N_GPIO];
  logic [NB-1:0]   flat_d;
  logic            wr_en;
  logic [BW-1:0]   bit_dec;
  logic            next_bit;
  logic            first_bit;

  // Writes are only honoured while no transfer is running; an out-of-range
  // address matches no word and so has no effect.
  assign wr_en = cfg_we & ~busy_q;

  // Next word contents, and the whole chain image built from them so that a
  // write in the start cycle is already visible to the first shifted bit.
  always_comb begin
    flat_d = '0;
    for (int i = 0; i < N_GPIO; i++) begin
      words_d[i] = words_q[i];
      if (wr_en && (cfg_addr == AW'(i))) begin
        words_d[i] = cfg_wdata;
      end
      flat_d[i*B +: B] = words_d[i];
    end
  end

  // Bit counter value maps directly onto the chain image index.
  assign bit_dec   = bit_q - BW'(1);
  assign next_bit  = flat_d[bit_dec];
  assign first_bit = flat_d[BIT_FIRST];

  // Combinational readback; unmatched addresses read as zero.
  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < N_GPIO; i++) begin
      if (cfg_addr == AW'(i)) begin
        cfg_rdata = words_q[i];
      end
    end
  end

  // Configuration word storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_GPIO; i++) begin
        words_q[i] <= DEFAULT_CFG;
      end
    end else begin
      for (int i = 0; i < N_GPIO; i++) begin
        words_q[i] <= words_d[i];
      end
    end
  end

  // Transfer sequencer; every chain output comes straight from a flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      sload_q <= 1'b0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT_LO;
            busy_q  <= 1'b1;
            bit_q   <= BIT_FIRST;
            sdata_q <= first_bit;
            sclk_q  <= 1'b0;
            div_q   <= '0;
          end
        end
        SHIFT_LO: begin
          if (div_q == HALF_LAST) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= SHIFT_HI;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        SHIFT_HI: begin
          if (div_q == HALF_LAST) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            if (bit_q != '0) begin
              bit_q   <= bit_dec;
              sdata_q <= next_bit;
              state_q <= SHIFT_LO;
            end else begin
              sdata_q <= 1'b0;
              state_q <= SETTLE;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        SETTLE: begin
          if (div_q == HALF_LAST) begin
            div_q   <= '0;
            sload_q <= 1'b1;
            state_q <= LOAD;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        LOAD: begin
          if (div_q == LOAD_LAST) begin
            div_q   <= '0;
            sload_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sclk_q  <= 1'b0;
          sdata_q <= 1'b0;
          sload_q <= 1'b0;
          div_q   <= '0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign serial_clock = sclk_q;
  assign serial_data  = sdata_q;
  assign serial_load  = sload_q;

endmodule
